// File: rtl/acumulador_8bits.sv
// Handshaked 8-bit accumulator: sums n_muestras operands with a sticky carry flag.
// Optional build macro ACUM_SATURACION_EN saturates suma at 8'hFF instead of wrapping.
module acumulador_8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] n_muestras,
  input  logic [7:0] dato,
  input  logic       dato_valid,
  output logic       dato_ready,
  output logic [7:0] suma,
  output logic       acarreo,
  output logic [3:0] cuenta,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] suma_d;
  logic          acarreo_d;
  logic [CW-1:0] cuenta_d;
  logic [CW-1:0] n_lat_q, n_lat_d;
  logic [DW:0]   sum9;
  logic [CW-1:0] cuenta_inc;

  assign sum9       = (DW+1)'(suma) + (DW+1)'(dato);
  assign cuenta_inc = cuenta + CW'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      suma    <= '0;
      acarreo <= 1'b0;
      cuenta  <= '0;
      n_lat_q <= '0;
    end else begin
      state_q <= state_d;
      suma    <= suma_d;
      acarreo <= acarreo_d;
      cuenta  <= cuenta_d;
      n_lat_q <= n_lat_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    suma_d    = suma;
    acarreo_d = acarreo;
    cuenta_d  = cuenta;
    n_lat_d   = n_lat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          suma_d    = '0;
          acarreo_d = 1'b0;
          cuenta_d  = '0;
          n_lat_d   = n_muestras;
          state_d   = (n_muestras == '0) ? DONE : ACUM;
        end
      end
      ACUM: begin
        if (dato_valid) begin
          acarreo_d = acarreo | sum9[DW];
`ifdef ACUM_SATURACION_EN
          // acarreo already set means an earlier add saturated this run
          suma_d = (sum9[DW] || acarreo) ? {DW{1'b1}} : sum9[DW-1:0];
`else
          suma_d = sum9[DW-1:0];
`endif
          cuenta_d = cuenta_inc;
          if (cuenta_inc == n_lat_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status decoded from registered state only
  assign dato_ready = (state_q == ACUM);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: doc/acumulador_8bits.md
ACUMULADOR_8BITS -- requirements
Module: acumulador_8bits

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a new accumulation run; sampled only in IDLE.
REQ-005 n_muestras  input  4  number of operands to accumulate, latched on accepted start.
REQ-006 dato  input  8  unsigned operand.
REQ-007 dato_valid  input  1  dato is valid this cycle.
REQ-008 dato_ready  output  1  block accepts dato this cycle.
REQ-009 suma  output  8  accumulator value.
REQ-010 acarreo  output  1  sticky flag: an 8-bit add in this run produced carry-out.
REQ-011 cuenta  output  4  operands accepted in the current run.
REQ-012 busy  output  1  high in ACUM and DONE.
REQ-013 done  output  1  single-cycle pulse marking run completion.

Function
REQ-014 FSM states SHALL be IDLE, ACUM and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-015 In IDLE, start=1 with n_muestras!=0 SHALL clear suma, acarreo and cuenta, latch n_muestras, and move to ACUM next edge.
REQ-016 In IDLE, start=1 with n_muestras=0 SHALL clear suma, acarreo and cuenta and move directly to DONE.
REQ-017 start SHALL be ignored in ACUM and DONE; a latched n_muestras SHALL NOT change mid-run.
REQ-018 dato_ready SHALL be 1 only in ACUM.
REQ-019 Transfer occurs on a rising edge where dato_valid=1 and dato_ready=1; exactly one operand per transfer.
REQ-020 On transfer: {carry,sum9} = suma + dato (9-bit); suma updates per REQ-030/031, acarreo |= carry, cuenta increments by 1.
REQ-021 dato_valid=0 in ACUM SHALL hold all state (stall, no timeout).
REQ-022 When the transfer makes cuenta equal the latched count, the FSM SHALL move to DONE on that same edge; the result SHALL be on suma in the first DONE cycle.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 suma, acarreo and cuenta SHALL hold their final values in IDLE until the next accepted start.
REQ-025 Latency: the run completes (done=1) exactly one cycle after the last transfer edge; zero-operand run: done=1 one cycle after the start edge.
REQ-026 dato_valid held high with no stall SHALL sustain one transfer per cycle.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force state IDLE, suma=8'h00, acarreo=0, cuenta=0, latched count=0, dato_ready=0, busy=0, done=0.
REQ-028 Reset mid-run SHALL discard the run; no done pulse SHALL be produced for it.
REQ-029 After rst_n releases, the first start SHALL be honoured on the first rising edge where it is sampled high.

Configuration
REQ-030 Without ACUM_SATURACION_EN defined, suma SHALL take sum9[7:0] (wrap modulo 256).
REQ-031 With ACUM_SATURACION_EN defined, suma SHALL become 8'hFF on carry and remain 8'hFF for the rest of the run; acarreo behaves identically in both builds.

Verification
REQ-032 The bench SHALL cover the following directed scenarios.
- start, n=3, data 10,20,30 back-to-back -> suma=60, acarreo=0, cuenta=3, done for one cycle, exactly one cycle after the third transfer.
- start, n=2, data 200,100 -> wrap build: suma=44, acarreo=1; ACUM_SATURACION_EN build: suma=255, acarreo=1.
- start, n=0 -> DONE next cycle, suma=0, cuenta=0, no dato_ready assertion.
- n=4 with dato_valid gaps of 2 cycles; start pulsed during ACUM -> suma equals the sum of the 4 data, latched n unchanged.
- rst_n low after 2 of 5 transfers -> all outputs zero asynchronously, no done; new run n=1, dato=7 -> suma=7.
- n=15, all data=17 -> wrap: suma=255, acarreo=0; one more run n=1, dato=1 -> suma=1, acarreo=0 (cleared on start).
